// File: rtl/sound_event_scheduler.sv
// Latches game sound requests, arbitrates bad > good > move and plays each as a timed
// tone burst followed by a silent gap; also owns the user mute toggle.
module sound_event_scheduler #(
   parameter int         CW       = 16,
   parameter int         DUR_BAD  = 4000,
   parameter int         DUR_GOOD = 2000,
   parameter int         DUR_MOVE = 500,
   parameter int         GAP      = 100,
   parameter logic [7:0] DIV_BAD  = 8'd120,
   parameter logic [7:0] DIV_GOOD = 8'd40,
   parameter logic [7:0] DIV_MOVE = 8'd80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_i,
   input  logic       goodColl_i,
   input  logic       badColl_i,
   input  logic [3:0] direction_i,
   output logic       tone_en_o,
   output logic [7:0] tone_div_o,
   output logic [1:0] active_src_o,
   output logic       muted_o
);

   if (DUR_BAD < 1 || DUR_BAD > 2**CW - 1 || DUR_GOOD < 1 || DUR_GOOD > 2**CW - 1 ||
       DUR_MOVE < 1 || DUR_MOVE > 2**CW - 1 || GAP < 1 || GAP > 2**CW - 1) begin : g_param_check
      $error("sound_event_scheduler: durations and GAP must lie in [1, 2**CW-1]");
   end

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_MOVE = 2'd1;
   localparam logic [1:0] SRC_GOOD = 2'd2;
   localparam logic [1:0] SRC_BAD  = 2'd3;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    pend_reg, pend_next;   // [0] move, [1] good, [2] bad
   logic [2:0]    ev_edge, grant;
   logic          button_prev_reg, good_prev_reg, bad_prev_reg;
   logic [3:0]    dir_prev_reg;
   logic          muted_reg, muted_next;
   logic          tone_en_reg, tone_en_next;
   logic [7:0]    div_reg, div_next;
   logic [1:0]    src_reg, src_next;
   logic [1:0]    sel;
   logic          button_edge, drop, try_grant;

   assign button_edge = button_i & ~button_prev_reg;
   assign ev_edge[0]  = (direction_i != dir_prev_reg) && (direction_i != 4'b0000);
   assign ev_edge[1]  = goodColl_i & ~good_prev_reg;
   assign ev_edge[2]  = badColl_i & ~bad_prev_reg;
   assign muted_next  = muted_reg ^ button_edge;
   // Any button edge either mutes or unmutes; in both cases event edges on that clk are dropped.
   assign drop        = muted_reg | button_edge;

   assign grant = {sel == SRC_BAD, sel == SRC_GOOD, sel == SRC_MOVE};

   for (genvar gi = 0; gi < 3; gi++) begin : g_pend
      assign pend_next[gi] = ~drop & ((pend_reg[gi] & ~grant[gi]) | ev_edge[gi]);
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      tone_en_next = tone_en_reg;
      div_next     = div_reg;
      src_next     = src_reg;
      sel          = SRC_NONE;
      try_grant    = 1'b0;
      if (drop) begin
         state_next   = S_IDLE;
         cnt_next     = '0;
         tone_en_next = 1'b0;
         div_next     = 8'd0;
         src_next     = SRC_NONE;
      end else begin
         case (state_reg)
            S_IDLE: try_grant = 1'b1;
            S_PLAY: begin
               if (pend_reg[2] && src_reg != SRC_BAD) begin
                  sel = SRC_BAD;
               end else if (cnt_reg == '0) begin
                  state_next   = S_GAP;
                  cnt_next     = CW'(GAP - 1);
                  tone_en_next = 1'b0;
                  div_next     = 8'd0;
                  src_next     = SRC_NONE;
               end else begin
                  cnt_next = cnt_reg - CW'(1);
               end
            end
            S_GAP: begin
               // Last gap clock doubles as IDLE's first clock, so bursts are exactly GAP apart.
               if (cnt_reg == '0) begin
                  state_next = S_IDLE;
                  try_grant  = 1'b1;
               end else begin
                  cnt_next = cnt_reg - CW'(1);
               end
            end
            default: state_next = S_IDLE;
         endcase
         if (try_grant) begin
            if (pend_reg[2])      sel = SRC_BAD;
            else if (pend_reg[1]) sel = SRC_GOOD;
            else if (pend_reg[0]) sel = SRC_MOVE;
         end
      end
      case (sel)
         SRC_BAD: begin
            state_next = S_PLAY; cnt_next = CW'(DUR_BAD - 1);
            tone_en_next = 1'b1; div_next = DIV_BAD; src_next = SRC_BAD;
         end
         SRC_GOOD: begin
            state_next = S_PLAY; cnt_next = CW'(DUR_GOOD - 1);
            tone_en_next = 1'b1; div_next = DIV_GOOD; src_next = SRC_GOOD;
         end
         SRC_MOVE: begin
            state_next = S_PLAY; cnt_next = CW'(DUR_MOVE - 1);
            tone_en_next = 1'b1; div_next = DIV_MOVE; src_next = SRC_MOVE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         pend_reg        <= 3'b000;
         button_prev_reg <= 1'b0;
         good_prev_reg   <= 1'b0;
         bad_prev_reg    <= 1'b0;
         dir_prev_reg    <= 4'b0000;
         muted_reg       <= 1'b0;
         tone_en_reg     <= 1'b0;
         div_reg         <= 8'd0;
         src_reg         <= SRC_NONE;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         pend_reg        <= pend_next;
         button_prev_reg <= button_i;
         good_prev_reg   <= goodColl_i;
         bad_prev_reg    <= badColl_i;
         dir_prev_reg    <= direction_i;
         muted_reg       <= muted_next;
         tone_en_reg     <= tone_en_next;
         div_reg         <= div_next;
         src_reg         <= src_next;
      end
   end

   assign tone_en_o    = tone_en_reg;
   assign tone_div_o   = div_reg;
   assign active_src_o = src_reg;
   assign muted_o      = muted_reg;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Scoreboard bench for sound_event_scheduler: stimulus queues expected bursts,
// a negedge monitor segments the tone output into bursts and compares them.
module tb_sound_event_scheduler;

   localparam int DUR_BAD  = 40;
   localparam int DUR_GOOD = 20;
   localparam int DUR_MOVE = 10;
   localparam int GAP      = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       button_i = 1'b0;
   logic       goodColl_i = 1'b0;
   logic       badColl_i = 1'b0;
   logic [3:0] direction_i = 4'b0000;
   logic       tone_en_o;
   logic [7:0] tone_div_o;
   logic [1:0] active_src_o;
   logic       muted_o;

   typedef struct {
      int src;
      int div;
      int len;
      int gap;   // silent cycles before the burst; -1 = not checked
   } burst_t;

   burst_t exp_q[$];
   int     checks = 0;
   int     passes = 0;

   sound_event_scheduler #(
      .CW(16), .DUR_BAD(DUR_BAD), .DUR_GOOD(DUR_GOOD), .DUR_MOVE(DUR_MOVE), .GAP(GAP),
      .DIV_BAD(8'd120), .DIV_GOOD(8'd40), .DIV_MOVE(8'd80)
   ) dut (
      .clk(clk), .rst(rst), .button_i(button_i), .goodColl_i(goodColl_i),
      .badColl_i(badColl_i), .direction_i(direction_i), .tone_en_o(tone_en_o),
      .tone_div_o(tone_div_o), .active_src_o(active_src_o), .muted_o(muted_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic wait_tone(input string name);
      int n = 0;
      while (!tone_en_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(tone_en_o), 1);
   endtask

   task automatic expect_burst(input int src, input int div, input int len, input int gap);
      burst_t b;
      b.src = src; b.div = div; b.len = len; b.gap = gap;
      exp_q.push_back(b);
   endtask

   // Monitor: split the output stream into bursts and compare each against the queue.
   logic in_burst = 1'b0;
   int   cur_src, cur_div, len, gap_seen;
   int   silent = 1000;
   always @(negedge clk) begin
      burst_t e;
      if (!tone_en_o) check("silent_outputs", int'({active_src_o, tone_div_o}), 0);
      if (in_burst && (!tone_en_o || int'(active_src_o) != cur_src || int'(tone_div_o) != cur_div)) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_burst: got src=%0d div=%0d len=%0d, required none",
                     cur_src, cur_div, len);
         end else begin
            e = exp_q.pop_front();
            $display("burst src=%0d div=%0d len=%0d gap=%0d", cur_src, cur_div, len, gap_seen);
            check("burst_src", cur_src, e.src);
            check("burst_div", cur_div, e.div);
            check("burst_len", len, e.len);
            if (e.gap >= 0) check("burst_gap", gap_seen, e.gap);
         end
         in_burst = 1'b0;
         silent   = 0;
      end
      if (!in_burst && tone_en_o) begin
         in_burst = 1'b1;
         cur_src  = int'(active_src_o);
         cur_div  = int'(tone_div_o);
         len      = 0;
         gap_seen = silent;
      end
      if (in_burst) len++;
      else if (silent < 1000) silent++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset held, then idle outputs
      repeat (3) @(negedge clk);
      check("reset_tone_en", int'(tone_en_o), 0);
      check("reset_src", int'(active_src_o), 0);
      check("reset_muted", int'(muted_o), 0);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("idle_tone_en", int'(tone_en_o), 0);
         check("idle_muted", int'(muted_o), 0);
      end

      // 2: single good burst from a 5-clk level
      expect_burst(2, 40, DUR_GOOD, -1);
      goodColl_i = 1'b1;
      repeat (5) @(negedge clk);
      goodColl_i = 1'b0;
      repeat (40) @(negedge clk);

      // 3: simultaneous good and bad
      expect_burst(3, 120, DUR_BAD, -1);
      expect_burst(2, 40, DUR_GOOD, GAP);
      goodColl_i = 1'b1;
      badColl_i  = 1'b1;
      repeat (3) @(negedge clk);
      goodColl_i = 1'b0;
      badColl_i  = 1'b0;
      repeat (90) @(negedge clk);

      // 4: move preempted by bad on its 4th tone clk
      expect_burst(1, 80, 5, -1);
      expect_burst(3, 120, DUR_BAD, 0);
      direction_i = 4'b0001;
      wait_tone("move_start");
      repeat (3) @(negedge clk);
      badColl_i = 1'b1;
      @(negedge clk);
      badColl_i = 1'b0;
      repeat (60) @(negedge clk);
      direction_i = 4'b0000;
      repeat (10) @(negedge clk);

      // same-source re-request during its own burst replays after the gap
      expect_burst(2, 40, DUR_GOOD, -1);
      expect_burst(2, 40, DUR_GOOD, GAP);
      goodColl_i = 1'b1;
      @(negedge clk);
      goodColl_i = 1'b0;
      wait_tone("rereq_start");
      repeat (2) @(negedge clk);
      goodColl_i = 1'b1;
      @(negedge clk);
      goodColl_i = 1'b0;
      repeat (60) @(negedge clk);

      // 5: mute mid good burst, event while muted, unmute
      expect_burst(2, 40, 5, -1);
      goodColl_i = 1'b1;
      wait_tone("mute_good_start");
      goodColl_i = 1'b0;
      repeat (4) @(negedge clk);
      button_i = 1'b1;
      @(negedge clk);
      check("mute_muted", int'(muted_o), 1);
      check("mute_tone_en", int'(tone_en_o), 0);
      check("mute_src", int'(active_src_o), 0);
      button_i = 1'b0;
      repeat (3) @(negedge clk);
      goodColl_i = 1'b1;
      repeat (2) @(negedge clk);
      goodColl_i = 1'b0;
      repeat (30) @(negedge clk);
      check("muted_still", int'(muted_o), 1);
      button_i = 1'b1;
      @(negedge clk);
      check("unmute_muted", int'(muted_o), 0);
      button_i = 1'b0;
      repeat (30) @(negedge clk);
      check("unmute_silent", int'(tone_en_o), 0);

      // 6: async reset mid bad burst drops the pending good
      expect_burst(3, 120, 10, -1);
      badColl_i = 1'b1;
      wait_tone("reset_bad_start");
      badColl_i = 1'b0;
      repeat (2) @(negedge clk);
      goodColl_i = 1'b1;
      repeat (7) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_tone_en", int'(tone_en_o), 0);
      check("async_rst_src", int'(active_src_o), 0);
      goodColl_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (60) @(negedge clk);
      check("post_rst_muted", int'(muted_o), 0);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
